prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side PRBS-7 (x^7+x^6+1) stream checker. Consumes a valid-qualified data stream,
//  self-synchronises to it, then counts errored words. Sits at the sink end of a pattern link,
//  opposite a PRBS stimulus source, so on-chip or bench loops can self-check.
// PARAMETERS
//  DATA_W    8   bits per beat, MSB first in time; must be >= 7
//  LOCK_CNT  4   consecutive matching words needed to enter LOCKED (>=1)
//  LOSS_CNT  4   consecutive errored words while LOCKED that force SEARCH (>=1)
//  CNT_W     16  width of the saturating counters
// PORTS
//  clk        in   1        clock; all logic on posedge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        in_data is a beat this cycle; no backpressure
//  in_data    in   DATA_W   received word; bit DATA_W-1 is oldest
//  clear      in   1        zero word_cnt/err_cnt (lock state unaffected)
//  locked     out  1        checker in LOCKED
//  err_pulse  out  1        1-cycle flag: the previous beat was errored while LOCKED
//  err_cnt    out  CNT_W    errored words seen while LOCKED, saturating
//  word_cnt   out  CNT_W    words checked while LOCKED, saturating
// BEHAVIOUR
//  - Reset: state=SEARCH, lfsr=0, match/loss counters=0, locked=0, err_pulse=0, err_cnt=0, word_cnt=0.
//  - LFSR step: nb = s[6]^s[5]; s <= {s[5:0],nb}; nb is the emitted bit. exp = next DATA_W nb's, first at MSB.
//  - Nothing changes on cycles with in_valid=0 (err_pulse drops to 0).
//  - SEARCH, per beat: match = (in_data==exp(s)) && s!=0 (zero seed never matches, so all-zero
//    streams never lock). match -> match_cnt++, else match_cnt=0. Always reseed s <= in_data[6:0].
//    When match makes match_cnt==LOCK_CNT, go to LOCKED; locked=1 from the next cycle.
//  - LOCKED, per beat: s <= advance(s, DATA_W). This is free-running, not reseeded, so one bad word
//    does not propagate. word_cnt++. Mismatch -> err_cnt++, err_pulse=1 next cycle, loss_cnt++.
//    Match -> loss_cnt=0. When loss_cnt reaches LOSS_CNT, go to SEARCH, match_cnt=0, locked=0 next cycle.
//    The LOSS_CNT-th errored word is still counted.
//  - Latency: one cycle from the sampled beat to locked, err_pulse and counter updates.
//  - Counters saturate at all-ones and never wrap.
//  - clear and a counted beat in the same cycle: the counter is loaded with that beat's increment (0 or 1).
//  - rst mid-stream overrides everything. Lock is re-acquired after LOCK_CNT+1 beats: 1 seed beat + LOCK_CNT matches.
// CONFIGURATION
//  PRBS_CHK_BITERR_EN defined: adds output bit_err_cnt [CNT_W]. It adds popcount(in_data^exp)
//  per LOCKED beat, saturating, and is cleared by rst/clear like err_cnt.
//  Undefined: the port and the popcount logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package prbs_pkg holds:
//    - state encoding SEARCH=1'b0 and LOCKED=1'b1;
//    - PRBS7_TAP_A=6, PRBS7_TAP_B=5, PRBS7_LEN=7;
//    - the all-zero-seed constant.
//    The source-side generator reuses it.
//  - Sub-module prbs7_adv is combinational: (s, DATA_W) -> {exp word, advanced state}.
//    It is shared with the generator.
// TESTING
//  1. rst 2 cycles, idle -> locked=0, err_pulse=0, err_cnt=0, word_cnt=0.
//  2. Clean PRBS7 stream from a model seeded 7'h7F, in_valid=1 continuously.
//     -> locked rises on cycle 6 after the first beat (1 seed + 4 matches + 1). err_cnt stays 0;
//     word_cnt increments once per beat.
//  3. Locked, flip bit 0 of one word -> err_pulse high exactly 1 cycle, err_cnt=1, locked stays 1.
//     The next clean words still match (no error propagation).
//  4. Locked, then 4 consecutive corrupted words -> err_cnt=4, locked=0 after the 4th.
//     Clean data resumes -> relock 5 beats later.
//  5. All-zero stream for 20 beats -> locked never asserts.
//     CNT_W=4 with 20 errors while locked -> err_cnt holds 4'hF.
//  6. clear coincident with an errored word -> err_cnt=1. rst asserted while LOCKED -> all outputs
//     at reset values next cycle. With PRBS_CHK_BITERR_EN, 3 flipped bits in one word -> bit_err_cnt=3.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg -- shared PRBS-7 (x^7 + x^6 + 1) definitions.
// The checker and the source-side pattern generator both use this package:
//   prbs_state_e  : checker lock state (SEARCH / LOCKED)
//   PRBS7_TAP_A/B : feedback taps (state bits 6 and 5)
//   PRBS7_LEN     : LFSR length
//   PRBS7_SEED_ZERO : the all-zero (lock-up) LFSR state
// -----------------------------------------------------------------------------
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;
  localparam int PRBS7_LEN   = 7;

  localparam logic [PRBS7_LEN-1:0] PRBS7_SEED_ZERO = '0;

endpackage

// File: rtl/prbs_checker_if.sv
// -----------------------------------------------------------------------------
// prbs_checker_if -- valid-qualified PRBS data stream (no backpressure).
//   in_valid : in_data carries a beat this cycle
//   in_data  : DATA_W-bit word, bit DATA_W-1 is the oldest bit in time
// Modports: master (stream source), slave (stream sink / checker).
// -----------------------------------------------------------------------------
interface prbs_checker_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);

endinterface

// File: rtl/prbs_checker_adv.sv
// -----------------------------------------------------------------------------
// prbs7_adv -- combinational PRBS-7 advance by DATA_W steps.
// Shared by the checker and the pattern generator.
//   i_s      : current LFSR state
//   o_exp    : the DATA_W bits the LFSR emits next, first emitted bit at MSB
//   o_s_next : LFSR state after those DATA_W steps
// -----------------------------------------------------------------------------
module prbs7_adv
  import prbs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [PRBS7_LEN-1:0] i_s,
  output logic [DATA_W-1:0]    o_exp,
  output logic [PRBS7_LEN-1:0] o_s_next
);

  logic [PRBS7_LEN-1:0] w_st;
  logic                 w_nb;

  // Unrolled serial LFSR: each step emits nb and shifts it in at the LSB,
  // so after the last step the state holds the newest 7 emitted bits.
  always_comb begin
    o_exp = '0;
    w_st  = i_s;
    w_nb  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      w_nb                = w_st[PRBS7_TAP_A] ^ w_st[PRBS7_TAP_B];
      o_exp[DATA_W-1-i]   = w_nb;
      w_st                = {w_st[PRBS7_LEN-2:0], w_nb};
    end
    o_s_next = w_st;
  end

endmodule

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker -- receive-side PRBS-7 stream checker.
// Self-synchronises to an incoming PRBS-7 stream, then counts checked and
// errored words while locked.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   clear        : zero word_cnt / err_cnt (lock state unaffected)
//   s_in         : stream sink (in_valid / in_data)
//   locked       : checker is in LOCKED
//   err_pulse    : 1-cycle flag, previous beat was errored while LOCKED
//   err_cnt      : errored words while LOCKED, saturating
//   word_cnt     : words checked while LOCKED, saturating
//   bit_err_cnt  : errored bits while LOCKED, saturating
//                  (present only when PRBS_CHK_BITERR_EN is defined)
// -----------------------------------------------------------------------------
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  prbs_checker_if.slave      s_in,
  output logic               locked,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   word_cnt
`ifdef PRBS_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0]   bit_err_cnt
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  prbs_state_e           r_state, w_state_next;
  logic [PRBS7_LEN-1:0]  r_s;
  logic [MW-1:0]         r_match_cnt;
  logic [LW-1:0]         r_loss_cnt;
  logic                  r_err_pulse;
  logic [CNT_W-1:0]      r_err_cnt, r_word_cnt;

  logic [DATA_W-1:0]     w_exp;
  logic [PRBS7_LEN-1:0]  w_s_adv;
  logic                  w_word_eq, w_match_search;
  logic [MW-1:0]         w_match_inc;
  logic [LW-1:0]         w_loss_inc;
  logic                  w_lock_hit, w_loss_hit;
  logic                  w_cnt_word, w_cnt_err;

  prbs7_adv #(.DATA_W(DATA_W)) u_adv (
    .i_s      (r_s),
    .o_exp    (w_exp),
    .o_s_next (w_s_adv)
  );

  assign w_word_eq      = (s_in.in_data == w_exp);
  // A zero seed predicts an all-zero word; refusing it keeps a dead link
  // (constant zeros) from ever looking like a locked pattern.
  assign w_match_search = w_word_eq && (r_s != PRBS7_SEED_ZERO);
  assign w_match_inc    = r_match_cnt + MW'(1);
  assign w_loss_inc     = r_loss_cnt + LW'(1);
  assign w_lock_hit     = w_match_search && (w_match_inc == MW'(LOCK_CNT));
  assign w_loss_hit     = !w_word_eq && (w_loss_inc == LW'(LOSS_CNT));
  assign w_cnt_word     = s_in.in_valid && (r_state == LOCKED);
  assign w_cnt_err      = w_cnt_word && !w_word_eq;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    if (s_in.in_valid) begin
      case (r_state)
        SEARCH:  if (w_lock_hit) w_state_next = LOCKED;
        LOCKED:  if (w_loss_hit) w_state_next = SEARCH;
        default: w_state_next = SEARCH;
      endcase
    end
  end

  // Datapath: LFSR tracking, lock/loss counters, error flag, statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s         <= PRBS7_SEED_ZERO;
      r_match_cnt <= '0;
      r_loss_cnt  <= '0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (s_in.in_valid) begin
        if (r_state == SEARCH) begin
          // Reseed from the newest 7 received bits every beat.
          r_s         <= s_in.in_data[PRBS7_LEN-1:0];
          r_loss_cnt  <= '0;
          r_match_cnt <= (w_match_search && !w_lock_hit) ? w_match_inc : '0;
        end else begin
          // Free-running while locked so a bad word cannot corrupt the
          // prediction of the following words.
          r_s <= w_s_adv;
          if (!w_word_eq) begin
            r_err_pulse <= 1'b1;
            if (w_loss_hit) begin
              r_loss_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_loss_cnt  <= w_loss_inc;
            end
          end else begin
            r_loss_cnt <= '0;
          end
        end
      end

      // clear loads this beat's increment so a coincident count is kept.
      if (clear)                           r_word_cnt <= CNT_W'(w_cnt_word);
      else if (w_cnt_word && !(&r_word_cnt)) r_word_cnt <= r_word_cnt + CNT_W'(1);

      if (clear)                           r_err_cnt <= CNT_W'(w_cnt_err);
      else if (w_cnt_err && !(&r_err_cnt))   r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

`ifdef PRBS_CHK_BITERR_EN
  localparam int PW = $clog2(DATA_W + 1);

  logic [CNT_W-1:0] r_bit_err_cnt;
  logic [PW-1:0]    w_pop;
  logic [CNT_W:0]   w_bit_sum;
  logic [DATA_W-1:0] w_diff;

  always_comb begin
    w_diff = s_in.in_data ^ w_exp;
    w_pop  = '0;
    for (int i = 0; i < DATA_W; i++) w_pop = w_pop + PW'(w_diff[i]);
  end

  assign w_bit_sum = {1'b0, r_bit_err_cnt} + (CNT_W+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst)                 r_bit_err_cnt <= '0;
    else if (clear)          r_bit_err_cnt <= w_cnt_word ? CNT_W'(w_pop) : '0;
    else if (w_cnt_word)     r_bit_err_cnt <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
  end

  assign bit_err_cnt = r_bit_err_cnt;
`endif

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker -- directed bench for prbs_checker.
// dut1: default parameters. dut2: CNT_W=4, LOSS_CNT=32 (stays locked through
// long error bursts so counter saturation can be observed). Both share the
// same stream, clock, reset and clear.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  prbs_checker_if #(.DATA_W(8)) bus ();

  logic        d1_locked, d1_err_pulse;
  logic [15:0] d1_err_cnt, d1_word_cnt;
  logic        d2_locked, d2_err_pulse;
  logic [3:0]  d2_err_cnt, d2_word_cnt;
`ifdef PRBS_CHK_BITERR_EN
  logic [15:0] d1_bit_err_cnt;
  logic [3:0]  d2_bit_err_cnt;
`endif

  prbs_checker #(.DATA_W(8), .LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(16)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .s_in       (bus.slave),
    .locked     (d1_locked),
    .err_pulse  (d1_err_pulse),
    .err_cnt    (d1_err_cnt),
    .word_cnt   (d1_word_cnt)
`ifdef PRBS_CHK_BITERR_EN
    ,
    .bit_err_cnt(d1_bit_err_cnt)
`endif
  );

  prbs_checker #(.DATA_W(8), .LOCK_CNT(4), .LOSS_CNT(32), .CNT_W(4)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .s_in       (bus.slave),
    .locked     (d2_locked),
    .err_pulse  (d2_err_pulse),
    .err_cnt    (d2_err_cnt),
    .word_cnt   (d2_word_cnt)
`ifdef PRBS_CHK_BITERR_EN
    ,
    .bit_err_cnt(d2_bit_err_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [6:0] g;   // reference generator state
  logic [7:0] w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference PRBS-7 source, first emitted bit at the MSB.
  task automatic next_word(output logic [7:0] word);
    logic nb;
    for (int i = 0; i < 8; i++) begin
      nb          = g[6] ^ g[5];
      word[7-i]   = nb;
      g           = {g[5:0], nb};
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic clr);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    clear        = clr;
    @(posedge clk);
    #1;
    clear        = 1'b0;
  endtask

  task automatic clean_beat();
    logic [7:0] cw;
    next_word(cw);
    drive(cw, 1'b0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clear        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset state
    do_reset();
    check("rst_locked",    d1_locked,    0);
    check("rst_err_pulse", d1_err_pulse, 0);
    check("rst_err_cnt",   d1_err_cnt,   0);
    check("rst_word_cnt",  d1_word_cnt,  0);

    // 2. Clean stream from seed 7F: seed beat + 4 matches -> locked
    g = 7'h7F;
    repeat (4) clean_beat();
    check("lock_not_yet", d1_locked, 0);
    clean_beat();
    check("lock_rise",      d1_locked,   1);
    check("lock_word_cnt0", d1_word_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      clean_beat();
      check("clean_word_cnt", d1_word_cnt, i);
      check("clean_err_cnt",  d1_err_cnt,  0);
      check("clean_pulse",    d1_err_pulse, 0);
    end

    // 3. Single bit-0 flip while locked
    next_word(w);
    drive(w ^ 8'h01, 1'b0);
    check("flip_pulse",    d1_err_pulse, 1);
    check("flip_err_cnt",  d1_err_cnt,   1);
    check("flip_locked",   d1_locked,    1);
    check("flip_word_cnt", d1_word_cnt,  4);
    clean_beat();
    check("flip_pulse_drop", d1_err_pulse, 0);
    check("flip_no_prop",    d1_err_cnt,   1);
    check("flip_word_cnt5",  d1_word_cnt,  5);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_word_cnt", d1_word_cnt, 5);
    check("idle_pulse",    d1_err_pulse, 0);
    clean_beat();
    check("resume_err_cnt",  d1_err_cnt,  1);
    check("resume_word_cnt", d1_word_cnt, 6);

    // 4. clear with a clean counted beat, then 4 corrupted words -> loss
    clean_beat();
    // (clear applied on the next beat together with its increment)
    next_word(w);
    drive(w, 1'b1);
    check("clear_word_cnt", d1_word_cnt, 1);
    check("clear_err_cnt",  d1_err_cnt,  0);
    for (int i = 1; i <= 3; i++) begin
      next_word(w);
      drive(~w, 1'b0);
      check("loss_still_locked", d1_locked,  1);
      check("loss_err_cnt",      d1_err_cnt, i);
    end
    next_word(w);
    drive(~w, 1'b0);
    check("loss_unlocked",  d1_locked,   0);
    check("loss_err_cnt4",  d1_err_cnt,  4);
    check("loss_word_cnt",  d1_word_cnt, 5);
    repeat (5) clean_beat();
    check("relock",         d1_locked,   1);
    check("relock_err_cnt", d1_err_cnt,  4);

    // 5a. All-zero stream never locks
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(8'h00, 1'b0);
      if (d1_locked !== 1'b0) check("zero_never_lock", d1_locked, 0);
    end
    check("zero_locked_end", d1_locked,  0);
    check("zero_err_cnt",    d1_err_cnt, 0);

    // 5b. 20 errored words while locked on a 4-bit counter -> saturates
    do_reset();
    g = 7'h7F;
    repeat (5) clean_beat();
    check("sat_locked_start", d2_locked, 1);
    repeat (20) begin
      next_word(w);
      drive(~w, 1'b0);
    end
    check("sat_err_cnt",    d2_err_cnt,  4'hF);
    check("sat_word_cnt",   d2_word_cnt, 4'hF);
    check("sat_d2_locked",  d2_locked,   1);
    check("sat_d1_lost",    d1_locked,   0);

    // 6. clear coincident with an errored word; reset while locked
    do_reset();
    g = 7'h7F;
    repeat (5) clean_beat();
    check("c6_locked", d1_locked, 1);
    next_word(w);
    drive(w ^ 8'h01, 1'b0);
    check("c6_err_before_clear", d1_err_cnt, 1);
    next_word(w);
    drive(w ^ 8'h07, 1'b1);
    check("c6_clear_err_cnt",  d1_err_cnt,  1);
    check("c6_clear_word_cnt", d1_word_cnt, 1);
`ifdef PRBS_CHK_BITERR_EN
    check("c6_bit_err_cnt", d1_bit_err_cnt, 3);
`endif
    clean_beat();
    check("c6_still_locked", d1_locked, 1);
    rst = 1'b1;
    clean_beat();
    rst = 1'b0;
    check("c6_rst_locked",    d1_locked,    0);
    check("c6_rst_pulse",     d1_err_pulse, 0);
    check("c6_rst_err_cnt",   d1_err_cnt,   0);
    check("c6_rst_word_cnt",  d1_word_cnt,  0);
`ifdef PRBS_CHK_BITERR_EN
    check("c6_rst_bit_err", d1_bit_err_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
